user_gpio_obi_sbr: RTL
======================

// Module: user_gpio_obi_sbr
// PURPOSE
// - OBI subordinate register block in user_domain, answering the croc_domain manager on the user_sbr port.
// - Drives user GPIO outputs gpio_o/gpio_out_en_o[OutCount-1:0].
// - Monitors one synchronised input pin (InPin) and reports edges through a counter and one interrupt line.
// PARAMETERS
// - GpioCount  16  width of gpio_in_sync_i
// - OutCount   5   number of driven GPIO bits (pins 0..OutCount-1); 1..32
// - InPin      5   index into gpio_in_sync_i of the monitored pin; its out_en is tied 0
// - CntWidth   16  edge-counter width, saturating; 1..32
// PORTS
// - clk_i           in   1                system clock
// - rst_ni          in   1                async active-low reset
// - obi_req_i       in   sbr_obi_req_t    req, a.addr, a.we, a.be, a.wdata, a.aid
// - obi_rsp_o       out  sbr_obi_rsp_t    gnt, rvalid, r.rdata, r.rid, r.err
// - gpio_in_sync_i  in   GpioCount        inputs, already synchronised by croc_domain
// - gpio_o          out  GpioCount        output data; bits >= OutCount are 0
// - gpio_out_en_o   out  GpioCount        output enables; bits >= OutCount and bit InPin are 0
// - irq_o           out  1                level interrupt = |(PEND & IRQ_EN)
// BEHAVIOUR
// - Reset (async, rst_ni=0): all registers 0; gpio_o=0, gpio_out_en_o=0, irq_o=0, rvalid=0, rdata=0, err=0.
// - Handshake:
//   - gnt = req, combinational; never stalls.
//   - Writes take effect on the clock edge of req&gnt.
//   - rvalid asserts exactly 1 cycle later for reads and writes, with rid=aid of that request.
//   - rdata: data for reads, 0 for writes.
//   - Back-to-back requests give back-to-back rvalid.
// - Address decode: addr[4:2] (word offset); addr[1:0] ignored; be honoured per byte on writes.
// - Register map:
//   - 0x00 OUT     rw  [OutCount-1:0] output data
//   - 0x04 OE      rw  [OutCount-1:0] output enable; bit InPin forced 0 when InPin<OutCount
//   - 0x08 IN      ro  gpio_in_sync_i zero-extended; writes ignored, err=0
//   - 0x0C IRQ_EN  rw  bit0 rising, bit1 falling
//   - 0x10 PEND    w1c bit0 rise seen, bit1 fall seen
//   - 0x14 EDGECNT r/clear  count of enabled-or-not edges of InPin; any write clears it
//   - Other offsets: err=1, rdata=0, no state change.
// - Edge detect:
//   - prev_q samples gpio_in_sync_i[InPin] each cycle.
//   - arm_q is set 1 cycle after reset release; edges are ignored while arm_q=0, so no spurious edge out of reset.
//   - rise = in & ~prev_q; fall = ~in & prev_q.
// - Simultaneous events:
//   - PEND: W1C clear and a new edge in the same cycle -> the edge wins (bit stays 1).
//   - EDGECNT: clear write and an edge in the same cycle -> result is 1.
//   - EDGECNT saturates at 2^CntWidth-1 and never wraps.
// - irq_o is registered: it rises 1 cycle after PEND/IRQ_EN make it true.
// - Latency: pin edge -> PEND set at cycle+1 -> irq_o at cycle+2.
// - Reset mid-transaction: any pending rvalid is dropped; no response is issued.
// CONFIGURATION
// - USER_GPIO_PWM_EN defined:
//   - 0x18 PWM_CFG: [15:0] period, [31:16] duty.
//   - 0x1C PWM_MASK: [OutCount-1:0] selects which OUT bits carry PWM.
//   - cnt runs 0..period and wraps to 0; pwm = (cnt < duty).
//   - period=0 -> cnt held at 0, pwm=0.
//   - duty>period -> pwm constantly 1.
//   - Any write to PWM_CFG restarts cnt at 0.
//   - gpio_o[i] = PWM_MASK[i] ? pwm : OUT[i].
// - USER_GPIO_PWM_EN undefined: 0x18/0x1C are unmapped (err=1); no PWM logic is built.
// TESTING
// - Write OUT=0x15, OE=0x3F (be=4'hF) -> gpio_o[4:0]=5'h15, gpio_out_en_o=16'h001F, rvalid at +1 with matching rid.
// - Write 0xAB to 0x00 with be=4'h0 -> OUT unchanged.
// - Read 0x20 -> err=1, rdata=0.
// - gpio_in_sync_i[5] held 1 from reset -> no PEND.
// - Then 1->0->1 on InPin -> EDGECNT=2, PEND=2'b11.
// - IRQ_EN=1 + rising edge -> irq_o=1 two cycles later.
// - Write PEND=1 in the same cycle as a new rise -> PEND bit0 stays 1.
// - Force EDGECNT to 0xFFFF with edges, apply one more edge -> stays 0xFFFF.
// - Write EDGECNT together with an edge -> reads 1.
// - PWM (macro on): period=3, duty=1, mask=1 -> gpio_o[0] pattern 1,0,0,0 repeating.
// - PWM period=0 -> gpio_o[0]=0.
// - Macro off: reading 0x18 -> err=1.

Source files
------------

// File: rtl/user_gpio_obi_pkg.sv
// OBI subordinate request/response types shared by user_gpio_obi_sbr and its manager.
package user_gpio_obi_pkg;

    localparam int unsigned AidWidth = 4;

    typedef struct packed {
        logic [31:0]         addr;
        logic                we;
        logic [3:0]          be;
        logic [31:0]         wdata;
        logic [AidWidth-1:0] aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        sbr_obi_a_chan_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]         rdata;
        logic [AidWidth-1:0] rid;
        logic                err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

endpackage

// File: rtl/user_gpio_obi_sbr.sv
// User-domain GPIO register block on OBI: drives output pins, counts edges on one input pin.
// Optional PWM on the output pins is built when USER_GPIO_PWM_EN is defined.
module user_gpio_obi_sbr
    import user_gpio_obi_pkg::*;
#(
    parameter int unsigned GpioCount = 16,
    parameter int unsigned OutCount  = 5,
    parameter int unsigned InPin     = 5,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  sbr_obi_req_t         obi_req_i,
    output sbr_obi_rsp_t         obi_rsp_o,
    input  logic [GpioCount-1:0] gpio_in_sync_i,
    output logic [GpioCount-1:0] gpio_o,
    output logic [GpioCount-1:0] gpio_out_en_o,
    output logic                 irq_o
);

    localparam logic [2:0] RegOut     = 3'd0;
    localparam logic [2:0] RegOe      = 3'd1;
    localparam logic [2:0] RegIn      = 3'd2;
    localparam logic [2:0] RegIrqEn   = 3'd3;
    localparam logic [2:0] RegPend    = 3'd4;
    localparam logic [2:0] RegCnt     = 3'd5;
    localparam logic [2:0] RegPwmCfg  = 3'd6;
    localparam logic [2:0] RegPwmMask = 3'd7;

    localparam logic [CntWidth-1:0] CntOne = 1;

    logic [OutCount-1:0] out_q, out_d, oe_q, oe_d, oe_mask, gpio_out;
    logic [1:0]          irq_en_q, irq_en_d, pend_q, pend_d, edge_ev;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                prev_q, arm_q, irq_q, rvalid_q, err_q;
    logic [31:0]         rdata_q, rd_mux, wmask, wdata_m;
    logic [31:0]         out_wr, oe_wr, irq_en_wr;
    logic [AidWidth-1:0] rid_q;
    logic [2:0]          word;
    logic                in_window, hit, wr_acc, pin, unused_bits;

    // Byte-enable mask applied to every write.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
        assign wmask[8*gi +: 8] = {8{obi_req_i.a.be[gi]}};
    end

    // The monitored pin can never be driven.
    for (genvar gi = 0; gi < OutCount; gi++) begin : g_oe_mask
        assign oe_mask[gi] = (gi != InPin);
    end

    assign wdata_m   = obi_req_i.a.wdata & wmask;
    assign out_wr    = (32'(out_q) & ~wmask) | wdata_m;
    assign oe_wr     = (32'(oe_q) & ~wmask) | wdata_m;
    assign irq_en_wr = (32'(irq_en_q) & ~wmask) | wdata_m;

    // Only the low 4 KiB window is decoded here; bits above belong to the interconnect.
    assign word      = obi_req_i.a.addr[4:2];
    assign in_window = (obi_req_i.a.addr[11:5] == '0);

    always_comb begin
        hit = 1'b0;
        case (word)
            RegOut, RegOe, RegIn, RegIrqEn, RegPend, RegCnt: hit = in_window;
`ifdef USER_GPIO_PWM_EN
            RegPwmCfg, RegPwmMask:                           hit = in_window;
`endif
            default:                                         hit = 1'b0;
        endcase
    end

    assign wr_acc = obi_req_i.req & obi_req_i.a.we & hit;

    assign pin        = gpio_in_sync_i[InPin];
    assign edge_ev[0] = arm_q & pin & ~prev_q;
    assign edge_ev[1] = arm_q & ~pin & prev_q;

    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        irq_en_d = irq_en_q;
        pend_d   = pend_q | edge_ev;
        cnt_d    = cnt_q;
        if (|edge_ev && !(&cnt_q)) begin
            cnt_d = cnt_q + CntOne;
        end
        if (wr_acc) begin
            case (word)
                RegOut:   out_d    = out_wr[OutCount-1:0];
                RegOe:    oe_d     = oe_wr[OutCount-1:0] & oe_mask;
                RegIrqEn: irq_en_d = irq_en_wr[1:0];
                // A fresh edge in the same cycle beats the clear.
                RegPend:  pend_d   = (pend_q & ~wdata_m[1:0]) | edge_ev;
                RegCnt:   cnt_d    = (|edge_ev) ? CntOne : '0;
                default:  ;
            endcase
        end
    end

`ifdef USER_GPIO_PWM_EN
    logic [31:0]         pwm_cfg_q, pwm_cfg_wr, pwm_mask_wr;
    logic [OutCount-1:0] pwm_mask_q;
    logic [15:0]         pwm_cnt_q, pwm_cnt_d, pwm_period, pwm_duty;
    logic                pwm, pwm_cfg_we, pwm_mask_we, unused_pwm;

    assign pwm_cfg_wr  = (pwm_cfg_q & ~wmask) | wdata_m;
    assign pwm_mask_wr = (32'(pwm_mask_q) & ~wmask) | wdata_m;
    assign pwm_cfg_we  = wr_acc && (word == RegPwmCfg);
    assign pwm_mask_we = wr_acc && (word == RegPwmMask);
    assign pwm_period  = pwm_cfg_q[15:0];
    assign pwm_duty    = pwm_cfg_q[31:16];
    assign pwm         = (pwm_period != '0) && (pwm_cnt_q < pwm_duty);
    assign unused_pwm  = ^pwm_mask_wr;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 16'd1;
        if (pwm_cfg_we || pwm_period == '0 || pwm_cnt_q >= pwm_period) begin
            pwm_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cfg_q  <= '0;
            pwm_mask_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            if (pwm_cfg_we) begin
                pwm_cfg_q <= pwm_cfg_wr;
            end
            if (pwm_mask_we) begin
                pwm_mask_q <= pwm_mask_wr[OutCount-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < OutCount; gi++) begin : g_pwm_mux
        assign gpio_out[gi] = pwm_mask_q[gi] ? pwm : out_q[gi];
    end
`else
    assign gpio_out = out_q;
`endif

    always_comb begin
        rd_mux = '0;
        case (word)
            RegOut:     rd_mux = 32'(out_q);
            RegOe:      rd_mux = 32'(oe_q);
            RegIn:      rd_mux = 32'(gpio_in_sync_i);
            RegIrqEn:   rd_mux = {30'd0, irq_en_q};
            RegPend:    rd_mux = {30'd0, pend_q};
            RegCnt:     rd_mux = 32'(cnt_q);
`ifdef USER_GPIO_PWM_EN
            RegPwmCfg:  rd_mux = pwm_cfg_q;
            RegPwmMask: rd_mux = 32'(pwm_mask_q);
`endif
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q    <= '0;
            oe_q     <= '0;
            irq_en_q <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            arm_q    <= 1'b0;
            irq_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            prev_q   <= pin;
            arm_q    <= 1'b1;
            irq_q    <= |(pend_q & irq_en_q);
            rvalid_q <= obi_req_i.req;
            rid_q    <= obi_req_i.a.aid;
            err_q    <= obi_req_i.req & ~hit;
            rdata_q  <= (obi_req_i.req && !obi_req_i.a.we && hit) ? rd_mux : '0;
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = rid_q;
        obi_rsp_o.r.err   = err_q;
    end

    for (genvar gi = 0; gi < GpioCount; gi++) begin : g_gpio
        if (gi < OutCount) begin : g_drv
            assign gpio_o[gi]        = gpio_out[gi];
            assign gpio_out_en_o[gi] = oe_q[gi];
        end else begin : g_tie
            assign gpio_o[gi]        = 1'b0;
            assign gpio_out_en_o[gi] = 1'b0;
        end
    end

    assign irq_o = irq_q;

    assign unused_bits = ^{obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0],
                           wdata_m, out_wr, oe_wr, irq_en_wr};

endmodule
